zx_bus_ctrl: RTL and testbench

ZX_BUS_CTRL -- requirements
Module: zx_bus_ctrl

---
 rtl/zx_bus_ctrl.sv | 166 ++++++++++++++++
 tb/tb_zx_bus_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/zx_bus_ctrl.sv
// zx_bus_ctrl: Z80 bus controller with 128K-style paging, a border port and
// a frame-interrupt generator. I/O port writes are taken from synchronised
// bus copies. The memory mapping is combinational from the raw address.
module zx_bus_ctrl #(
  parameter int PAGE_W   = 3,
  parameter int INT_LEN  = 32,
  parameter int BORDER_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         A,
  input  logic [7:0]          D,
  input  logic                nMREQ,
  input  logic                nIORQ,
  input  logic                nRD,
  input  logic                nWR,
  input  logic                nM1,
  input  logic                vblank,
  output logic                nINT,
  output logic                mem_rom,
  output logic [PAGE_W-1:0]   mem_page,
  output logic                mem_wren,
  output logic [PAGE_W-1:0]   scr_page,
  output logic [BORDER_W-1:0] border,
  output logic                locked,
  output logic                dbg_int_state
);

  // Handshake: none. The CPU bus is a free-running asynchronous strobe bus.
  // An I/O write is recognised once per synchronised nWR falling edge.

  localparam int RAM_BITS = (PAGE_W < 3) ? PAGE_W : 3;

  typedef enum logic {S_IDLE = 1'b0, S_ASSERT = 1'b1} int_state_t;

  // Synchronisers for the bus strobes, the decoded address bits
  // {A15, A1, A0}, the data bits that are used, and vblank.
  logic       r_wr_s1, r_wr_s2, r_wr_s3;
  logic       r_iorq_s1, r_iorq_s2;
  logic       r_m1_s1, r_m1_s2;
  logic [2:0] r_a_s1, r_a_s2;
  logic [5:0] r_d_s1, r_d_s2;
  logic       r_vb_s1, r_vb_s2, r_vb_prev;
  logic [1:0] r_fill;
  logic       r_vb_arm;

  logic [PAGE_W-1:0]   r_ram_sel;
  logic                r_scr_sel;
  logic                r_rom_sel;
  logic                r_locked;
  logic [BORDER_W-1:0] r_border;

  int_state_t r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;

  logic w_wr_event, w_border_wr, w_page_wr, w_vb_rise, w_ack;

  // Bring the asynchronous bus and vblank into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_s1   <= 1'b1; r_wr_s2   <= 1'b1; r_wr_s3 <= 1'b1;
      r_iorq_s1 <= 1'b1; r_iorq_s2 <= 1'b1;
      r_m1_s1   <= 1'b1; r_m1_s2   <= 1'b1;
      r_a_s1    <= 3'b0; r_a_s2    <= 3'b0;
      r_d_s1    <= 6'b0; r_d_s2    <= 6'b0;
      r_vb_s1   <= 1'b0; r_vb_s2   <= 1'b0; r_vb_prev <= 1'b0;
      r_fill    <= 2'b00;
      r_vb_arm  <= 1'b0;
    end else begin
      r_wr_s1   <= nWR;       r_wr_s2   <= r_wr_s1;   r_wr_s3 <= r_wr_s2;
      r_iorq_s1 <= nIORQ;     r_iorq_s2 <= r_iorq_s1;
      r_m1_s1   <= nM1;       r_m1_s2   <= r_m1_s1;
      r_a_s1    <= {A[15], A[1], A[0]};
      r_a_s2    <= r_a_s1;
      r_d_s1    <= D[5:0];    r_d_s2    <= r_d_s1;
      r_vb_s1   <= vblank;    r_vb_s2   <= r_vb_s1;   r_vb_prev <= r_vb_s2;
      r_fill    <= {r_fill[0], 1'b1};
      // Only arm edge detection after a genuine low has been seen, so a
      // vblank already high when reset is released does not fire.
      if (r_fill[1] && !r_vb_s2) r_vb_arm <= 1'b1;
    end
  end

  assign w_wr_event  = !r_wr_s2 && r_wr_s3 && !r_iorq_s2;
  assign w_border_wr = w_wr_event && !r_a_s2[0];
  assign w_page_wr   = w_wr_event && !r_a_s2[2] && !r_a_s2[1] && !r_locked;
  assign w_vb_rise   = r_vb_s2 && !r_vb_prev && r_vb_arm;
  assign w_ack       = !r_m1_s2 && !r_iorq_s2;

  // Border and paging registers; one OUT may hit both decodes at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_border  <= '0;
      r_ram_sel <= '0;
      r_scr_sel <= 1'b0;
      r_rom_sel <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      if (w_border_wr) r_border <= r_d_s2[BORDER_W-1:0];
      if (w_page_wr) begin
        r_ram_sel <= PAGE_W'(r_d_s2[RAM_BITS-1:0]);
        r_scr_sel <= r_d_s2[3];
        r_rom_sel <= r_d_s2[4];
        r_locked  <= r_d_s2[5];
      end
    end
  end

  // Interrupt FSM state and pulse counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: a rising vblank starts a pulse; ack or expiry ends it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    nINT        = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_vb_rise) begin
          w_state_nxt = S_ASSERT;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_ASSERT: begin
        nINT = 1'b0;
        if (w_ack || (r_cnt == 8'(INT_LEN - 1))) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Physical mapping of the current CPU access from the raw address.
  always_comb begin
    mem_rom  = 1'b0;
    mem_page = '0;
    case (A[15:14])
      2'b00: begin mem_rom = 1'b1; mem_page = PAGE_W'(r_rom_sel); end
      2'b01: mem_page = PAGE_W'(5);
      2'b10: mem_page = PAGE_W'(2);
      default: mem_page = r_ram_sel;
    endcase
    mem_wren = !nMREQ && !nWR && !mem_rom;
  end

  assign scr_page      = r_scr_sel ? PAGE_W'(7) : PAGE_W'(5);
  assign border        = r_border;
  assign locked        = r_locked;
  assign dbg_int_state = (r_state == S_ASSERT);

endmodule

// File: tb/tb_zx_bus_ctrl.sv
// Directed bench for zx_bus_ctrl: port writes, paging, lock, memory
// mapping, interrupt pulse length, acknowledge, retrigger and reset.
module tb_zx_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] A = 16'h0000;
  logic [7:0]  D = 8'h00;
  logic        nMREQ = 1'b1, nIORQ = 1'b1, nRD = 1'b1, nWR = 1'b1, nM1 = 1'b1;
  logic        vblank = 1'b0;
  logic        nINT, mem_rom, mem_wren, locked, dbg_int_state;
  logic [2:0]  mem_page, scr_page, border;

  int total = 0;
  int bad = 0;

  // Clock and reset
  always #5 clk = ~clk;

  zx_bus_ctrl #(.PAGE_W(3), .INT_LEN(32), .BORDER_W(3)) dut (
    .clk(clk), .reset(reset), .A(A), .D(D), .nMREQ(nMREQ), .nIORQ(nIORQ),
    .nRD(nRD), .nWR(nWR), .nM1(nM1), .vblank(vblank), .nINT(nINT),
    .mem_rom(mem_rom), .mem_page(mem_page), .mem_wren(mem_wren),
    .scr_page(scr_page), .border(border), .locked(locked),
    .dbg_int_state(dbg_int_state)
  );

  // Driver tasks (all inputs change on the falling edge)
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic do_out(input logic [15:0] a, input logic [7:0] d);
    A = a; D = d; nIORQ = 1'b0;
    tick();
    nWR = 1'b0;
    repeat (4) tick();
    nWR = 1'b1; nIORQ = 1'b1;
    repeat (3) tick();
    A = 16'h0000;
    #1;
  endtask

  // Raise vblank and measure the delay to nINT low and the low length.
  // ack_at / retrig_at are indices of low samples (0 disables).
  task automatic run_pulse(input int ack_at, input int retrig_at,
                           output int lat, output int len);
    vblank = 1'b1;
    lat = 0;
    while (nINT === 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    len = 0;
    while (nINT === 1'b0 && len < 100) begin
      len++;
      if (len == ack_at) begin nM1 = 1'b0; nIORQ = 1'b0; end
      if (retrig_at != 0 && len == retrig_at) vblank = 1'b0;
      if (retrig_at != 0 && len == retrig_at + 3) vblank = 1'b1;
      tick();
    end
    nM1 = 1'b1; nIORQ = 1'b1; vblank = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++; if (border !== 3'd0) begin bad++; $display("FAIL reset_border got=%0d exp=0", border); end
    total++; if (nINT !== 1'b1) begin bad++; $display("FAIL reset_nint got=%b exp=1", nINT); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    total++; if (scr_page !== 3'd5) begin bad++; $display("FAIL reset_scr_page got=%0d exp=5", scr_page); end
    total++; if (dbg_int_state !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", dbg_int_state); end
    total++; if (mem_rom !== 1'b1 || mem_page !== 3'd0 || mem_wren !== 1'b0) begin
      bad++; $display("FAIL reset_map got=rom%b page%0d wren%b exp=rom1 page0 wren0", mem_rom, mem_page, mem_wren);
    end
    reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_border();
    A = 16'h00FE; D = 8'h05; nIORQ = 1'b0;
    tick();
    nWR = 1'b0;
    repeat (2) tick();
    total++; if (border !== 3'd0) begin bad++; $display("FAIL border_early got=%0d exp=0", border); end
    tick();
    total++; if (border !== 3'd5) begin bad++; $display("FAIL border_lat3 got=%0d exp=5", border); end
    repeat (2) tick();
    nWR = 1'b1; nIORQ = 1'b1;
    repeat (3) tick();
    A = 16'hC000; #1;
    total++; if (mem_page !== 3'd0 || locked !== 1'b0) begin
      bad++; $display("FAIL border_paging got=page%0d lock%b exp=page0 lock0", mem_page, locked);
    end
  endtask

  task automatic test_paging();
    do_out(16'h7FFD, 8'h17);
    A = 16'hC123; #1;
    total++; if (mem_page !== 3'd7 || mem_rom !== 1'b0) begin
      bad++; $display("FAIL page_c123 got=page%0d rom%b exp=page7 rom0", mem_page, mem_rom);
    end
    A = 16'h0100; #1;
    total++; if (mem_page !== 3'd1 || mem_rom !== 1'b1) begin
      bad++; $display("FAIL page_0100 got=page%0d rom%b exp=page1 rom1", mem_page, mem_rom);
    end
    total++; if (scr_page !== 3'd5) begin bad++; $display("FAIL page_scr got=%0d exp=5", scr_page); end
    total++; if (border !== 3'd5) begin bad++; $display("FAIL page_border_kept got=%0d exp=5", border); end
  endtask

  task automatic test_both();
    do_out(16'h7FFC, 8'h0A);
    total++; if (border !== 3'd2) begin bad++; $display("FAIL both_border got=%0d exp=2", border); end
    total++; if (scr_page !== 3'd7) begin bad++; $display("FAIL both_scr got=%0d exp=7", scr_page); end
    A = 16'hC000; #1;
    total++; if (mem_page !== 3'd2) begin bad++; $display("FAIL both_ram got=%0d exp=2", mem_page); end
    A = 16'h0000; #1;
    total++; if (mem_page !== 3'd0 || mem_rom !== 1'b1) begin
      bad++; $display("FAIL both_rom got=page%0d rom%b exp=page0 rom1", mem_page, mem_rom);
    end
  endtask

  task automatic test_lock();
    do_reset();
    do_out(16'h7FFD, 8'h20);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_set got=%b exp=1", locked); end
    do_out(16'h7FFD, 8'h03);
    A = 16'hC000; #1;
    total++; if (mem_page !== 3'd0) begin bad++; $display("FAIL lock_ignored got=%0d exp=0", mem_page); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_held got=%b exp=1", locked); end
    do_reset();
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_reset got=%b exp=0", locked); end
  endtask

  task automatic test_mem_wren();
    nMREQ = 1'b0; nWR = 1'b0; A = 16'h1000; #1;
    total++; if (mem_wren !== 1'b0) begin bad++; $display("FAIL wren_rom got=%b exp=0", mem_wren); end
    A = 16'h4000; #1;
    total++; if (mem_wren !== 1'b1 || mem_page !== 3'd5) begin
      bad++; $display("FAIL wren_4000 got=wren%b page%0d exp=wren1 page5", mem_wren, mem_page);
    end
    A = 16'h8000; #1;
    total++; if (mem_wren !== 1'b1 || mem_page !== 3'd2) begin
      bad++; $display("FAIL wren_8000 got=wren%b page%0d exp=wren1 page2", mem_wren, mem_page);
    end
    nWR = 1'b1; #1;
    total++; if (mem_wren !== 1'b0) begin bad++; $display("FAIL wren_idle got=%b exp=0", mem_wren); end
    nMREQ = 1'b1; A = 16'h0000;
    repeat (4) tick();
  endtask

  task automatic test_interrupt();
    int lat, len;
    run_pulse(0, 0, lat, len);
    total++; if (lat !== 3) begin bad++; $display("FAIL int_latency got=%0d exp=3", lat); end
    total++; if (len !== 32) begin bad++; $display("FAIL int_len got=%0d exp=32", len); end
    run_pulse(9, 0, lat, len);
    total++; if (len !== 11) begin bad++; $display("FAIL int_ack_len got=%0d exp=11", len); end
    run_pulse(0, 5, lat, len);
    total++; if (len !== 32) begin bad++; $display("FAIL int_retrig_len got=%0d exp=32", len); end
  endtask

  task automatic test_reset_mid();
    int lat, len, lows, n;
    do_out(16'h00FE, 8'h03);
    total++; if (border !== 3'd3) begin bad++; $display("FAIL rmid_border_pre got=%0d exp=3", border); end
    vblank = 1'b1;
    n = 0;
    while (nINT === 1'b1 && n < 50) begin tick(); n++; end
    repeat (5) tick();
    total++; if (nINT !== 1'b0) begin bad++; $display("FAIL rmid_in_pulse got=%b exp=0", nINT); end
    reset = 1'b1;
    tick();
    total++; if (nINT !== 1'b1 || border !== 3'd0) begin
      bad++; $display("FAIL rmid_reset got=nint%b border%0d exp=nint1 border0", nINT, border);
    end
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (nINT === 1'b0) lows++;
    end
    total++; if (lows !== 0) begin bad++; $display("FAIL rmid_vb_high got=%0d exp=0", lows); end
    vblank = 1'b0;
    repeat (5) tick();
    run_pulse(0, 0, lat, len);
    total++; if (lat !== 3 || len !== 32) begin
      bad++; $display("FAIL rmid_rearm got=lat%0d len%0d exp=lat3 len32", lat, len);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_border();
    test_paging();
    test_both();
    test_lock();
    test_mem_wren();
    test_interrupt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
